// File: rtl/thor2021_branch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : thor2021_branch_sched (with Thor2021_pkg, thor2021_branch_eval)
// | Description : Shared branch-evaluation scheduler. It arbitrates round-robin
// |               between two issue slots for one internal branch-condition
// |               evaluator. It sequences the decrement of Ra ahead of the
// |               compare for DJxx ops. The decision, decremented count and
// |               tag are returned on a valid/ready result port.
// | Ports       : clk_i, rst_i (sync, active-high)
// |               req{0,1}_valid_i / req{0,1}_ready_o / req{0,1}_inst_i /
// |               req{0,1}_a_i / req{0,1}_b_i / req{0,1}_tag_i : issue slots
// |               res_valid_o / res_ready_i / res_tag_o / res_src_o /
// |               res_takb_o / res_dec_o / res_decwr_o : result port
// |               busy_o : scheduler not idle
// | Config      : THOR2021_DJ_EN - when defined, DJxx ops decrement Ra in a
// |               dedicated DEC cycle and compare the decremented value. When
// |               undefined, DJxx ops are evaluated like plain branches on the
// |               original Ra, and no write-back is requested.
// | Revision    : 1.0 - initial release
// +--------------------------------------------------------------------------+

package Thor2021_pkg;
    typedef logic [63:0] Value;

    typedef struct packed {
        logic [24:0] payload;   // register / displacement fields, not used here
        logic [6:0]  opcode;
    } br_fmt_t;

    typedef struct packed {
        br_fmt_t br;
    } Instruction;

    // Opcode = {class, condition}
    localparam logic [2:0] c_cls_br = 3'b010;
    localparam logic [2:0] c_cls_dj = 3'b011;

    localparam logic [3:0] c_cc_eq  = 4'h0;
    localparam logic [3:0] c_cc_ne  = 4'h1;
    localparam logic [3:0] c_cc_lt  = 4'h2;
    localparam logic [3:0] c_cc_ge  = 4'h3;
    localparam logic [3:0] c_cc_le  = 4'h4;
    localparam logic [3:0] c_cc_gt  = 4'h5;
    localparam logic [3:0] c_cc_ltu = 4'h6;
    localparam logic [3:0] c_cc_geu = 4'h7;
    localparam logic [3:0] c_cc_leu = 4'h8;
    localparam logic [3:0] c_cc_gtu = 4'h9;
    localparam logic [3:0] c_cc_bc  = 4'hA;
    localparam logic [3:0] c_cc_bs  = 4'hB;
    localparam logic [3:0] c_cc_eqz = 4'hC;
    localparam logic [3:0] c_cc_nez = 4'hD;

    localparam logic [6:0] c_op_jeq   = {c_cls_br, c_cc_eq};
    localparam logic [6:0] c_op_jne   = {c_cls_br, c_cc_ne};
    localparam logic [6:0] c_op_jlt   = {c_cls_br, c_cc_lt};
    localparam logic [6:0] c_op_jge   = {c_cls_br, c_cc_ge};
    localparam logic [6:0] c_op_jle   = {c_cls_br, c_cc_le};
    localparam logic [6:0] c_op_jgt   = {c_cls_br, c_cc_gt};
    localparam logic [6:0] c_op_jltu  = {c_cls_br, c_cc_ltu};
    localparam logic [6:0] c_op_jleu  = {c_cls_br, c_cc_leu};
    localparam logic [6:0] c_op_jgtu  = {c_cls_br, c_cc_gtu};
    localparam logic [6:0] c_op_jbc   = {c_cls_br, c_cc_bc};
    localparam logic [6:0] c_op_jbs   = {c_cls_br, c_cc_bs};
    localparam logic [6:0] c_op_jeqz  = {c_cls_br, c_cc_eqz};
    localparam logic [6:0] c_op_djeq  = {c_cls_dj, c_cc_eq};
    localparam logic [6:0] c_op_djbs  = {c_cls_dj, c_cc_bs};
    localparam logic [6:0] c_op_djnez = {c_cls_dj, c_cc_nez};

    // Condition codes E and F are unassigned in both classes.
    function automatic logic is_known(input logic [6:0] op);
        return ((op[6:4] == c_cls_br) || (op[6:4] == c_cls_dj)) && (op[3:0] <= c_cc_nez);
    endfunction

    function automatic logic is_dj(input logic [6:0] op);
        return (op[6:4] == c_cls_dj) && (op[3:0] <= c_cc_nez);
    endfunction
endpackage

// Combinational branch-condition evaluator; DJ ops share the plain conditions.
module thor2021_branch_eval
    import Thor2021_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  Value       a_i,
    input  Value       b_i,
    output logic       takb_o
);
    logic w_bit;
    assign w_bit = a_i[b_i[5:0]];

    always_comb begin
        takb_o = 1'b0;
        if (is_known(opcode_i)) begin
            case (opcode_i[3:0])
                c_cc_eq:  takb_o = (a_i == b_i);
                c_cc_ne:  takb_o = (a_i != b_i);
                c_cc_lt:  takb_o = ($signed(a_i) <  $signed(b_i));
                c_cc_ge:  takb_o = ($signed(a_i) >= $signed(b_i));
                c_cc_le:  takb_o = ($signed(a_i) <= $signed(b_i));
                c_cc_gt:  takb_o = ($signed(a_i) >  $signed(b_i));
                c_cc_ltu: takb_o = (a_i <  b_i);
                c_cc_geu: takb_o = (a_i >= b_i);
                c_cc_leu: takb_o = (a_i <= b_i);
                c_cc_gtu: takb_o = (a_i >  b_i);
                c_cc_bc:  takb_o = ~w_bit;
                c_cc_bs:  takb_o = w_bit;
                c_cc_eqz: takb_o = (a_i == 64'd0);
                c_cc_nez: takb_o = (a_i != 64'd0);
                default:  takb_o = 1'b0;
            endcase
        end
    end
endmodule

module thor2021_branch_sched
    import Thor2021_pkg::*;
#(
    parameter int TAGW = 5
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  Instruction      req0_inst_i,
    input  Value            req0_a_i,
    input  Value            req0_b_i,
    input  logic [TAGW-1:0] req0_tag_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  Instruction      req1_inst_i,
    input  Value            req1_a_i,
    input  Value            req1_b_i,
    input  logic [TAGW-1:0] req1_tag_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [TAGW-1:0] res_tag_o,
    output logic            res_src_o,
    output logic            res_takb_o,
    output Value            res_dec_o,
    output logic            res_decwr_o,
    output logic            busy_o
);
`ifdef THOR2021_DJ_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEC = 2'd1, S_EVAL = 2'd2, S_HOLD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd2, S_HOLD = 2'd3} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic [6:0]      r_op;
    Value            r_a;
    Value            r_b;
    logic [TAGW-1:0] r_tag;
    logic            r_src;
    logic            r_dj;
    logic            r_takb;
    Value            r_dec;
    logic            r_decwr;

    logic            w_gnt_any;
    logic            w_gnt;
    logic            w_idle;
    logic            w_accept;
    logic [6:0]      w_in_op;
    logic            w_takb;
    logic            w_unused_inst;

    // Only the opcode field of the instruction matters to the scheduler.
    assign w_unused_inst = ^{req0_inst_i.br.payload, req1_inst_i.br.payload};

    // Round-robin: on a tie the slot not granted last time wins.
    always_comb begin
        w_gnt_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = req1_valid_i;
        end
    end

    // Gated by reset so neither slot sees ready while reset is held.
    assign w_idle   = (r_state == S_IDLE) & ~rst_i;
    assign w_accept = w_idle & w_gnt_any;
    assign w_in_op  = w_gnt ? req1_inst_i.br.opcode : req0_inst_i.br.opcode;

    thor2021_branch_eval u_eval (
        .opcode_i (r_op),
        .a_i      (r_a),
        .b_i      (r_b),
        .takb_o   (w_takb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req0_ready_o = w_accept & ~w_gnt;
        req1_ready_o = w_accept & w_gnt;
        res_valid_o  = (r_state == S_HOLD);
        busy_o       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef THOR2021_DJ_EN
                    w_state_nxt = is_dj(w_in_op) ? S_DEC : S_EVAL;
`else
                    w_state_nxt = S_EVAL;
`endif
                end
            end
`ifdef THOR2021_DJ_EN
            S_DEC:   w_state_nxt = S_EVAL;
`endif
            S_EVAL:  w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, decrement in DEC, register result in EVAL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_tag        <= '0;
            r_src        <= 1'b0;
            r_dj         <= 1'b0;
            r_takb       <= 1'b0;
            r_dec        <= '0;
            r_decwr      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_in_op;
                        r_a          <= w_gnt ? req1_a_i   : req0_a_i;
                        r_b          <= w_gnt ? req1_b_i   : req0_b_i;
                        r_tag        <= w_gnt ? req1_tag_i : req0_tag_i;
                        r_src        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_dj         <= 1'b0;
                    end
                end
`ifdef THOR2021_DJ_EN
                S_DEC: begin
                    r_a  <= r_a - 64'd1;
                    r_dj <= 1'b1;
                end
`endif
                S_EVAL: begin
                    r_takb  <= w_takb;
                    r_dec   <= r_dj ? r_a : '0;
                    r_decwr <= r_dj;
                end
                default: ;
            endcase
        end
    end

    assign res_tag_o   = r_tag;
    assign res_src_o   = r_src;
    assign res_takb_o  = r_takb;
    assign res_dec_o   = r_dec;
    assign res_decwr_o = r_decwr;
endmodule
`default_nettype wire

// File: tb/tb_thor2021_branch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_thor2021_branch_sched
// | Description : Directed, table-driven bench for thor2021_branch_sched with
// |               hand-written sequences for contention, backpressure and
// |               reset during an operation. DJ expectations follow
// |               THOR2021_DJ_EN.
// | Revision    : 1.0 - initial release
// +--------------------------------------------------------------------------+
module tb_thor2021_branch_sched;
    import Thor2021_pkg::*;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    Instruction req0_inst, req1_inst;
    Value       req0_a, req0_b, req1_a, req1_b;
    logic [4:0] req0_tag, req1_tag;
    logic       res_valid, res_ready, res_src, res_takb, res_decwr, busy;
    logic [4:0] res_tag;
    Value       res_dec;

    int n_checks = 0;
    int n_errors = 0;

    thor2021_branch_sched #(.TAGW(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_inst_i  (req0_inst),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_tag_i   (req0_tag),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_inst_i  (req1_inst),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_tag_i   (req1_tag),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_tag_o    (res_tag),
        .res_src_o    (res_src),
        .res_takb_o   (res_takb),
        .res_dec_o    (res_dec),
        .res_decwr_o  (res_decwr),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [6:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic        exp_takb;
        logic [63:0] exp_dec;
        logic        exp_decwr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int slot, input logic [6:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic [4:0] tag, input logic tk,
                                input logic [63:0] dec, input logic dw, input int lat);
        vec_t v;
        v.slot = slot; v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.exp_takb = tk; v.exp_dec = dec; v.exp_decwr = dw; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int slot, input logic v, input logic [6:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        Instruction inst;
        inst = '0;
        inst.br.opcode = op;
        if (slot == 0) begin
            req0_valid = v; req0_inst = inst; req0_a = a; req0_b = b; req0_tag = tag;
        end else begin
            req1_valid = v; req1_inst = inst; req1_a = a; req1_b = b; req1_tag = tag;
        end
    endtask

    // Issues one request, waits for accept, then measures latency to res_valid.
    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        int  lat;
        bit  got;
        bit  rdy;
        string tname;
        tname = $sformatf("vec%0d", idx);
        @(negedge clk);
        res_ready = 1'b1;
        drive(v.slot, 1'b1, v.op, v.a, v.b, v.tag);
        #1;
        n = 0;
        rdy = (v.slot == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 10) begin
            @(negedge clk); #1;
            rdy = (v.slot == 0) ? req0_ready : req1_ready;
            n++;
        end
        chk({tname, " accept"}, 64'(rdy), 64'd1);
        if (!rdy) begin
            drive(v.slot, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
            return;
        end
        @(posedge clk); #1;
        drive(v.slot, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk({tname, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tname, " takb"}, 64'(res_takb), 64'(v.exp_takb));
        chk({tname, " tag"}, 64'(res_tag), 64'(v.tag));
        chk({tname, " src"}, 64'(res_src), 64'(v.slot));
        chk({tname, " dec"}, res_dec, v.exp_dec);
        chk({tname, " decwr"}, 64'(res_decwr), 64'(v.exp_decwr));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gr[4];
        int   rs[4];
        int   rt[4];
        int   rg[4];
        int   ng;
        int   nr;
        bit   ok;
        bit   seen;
        logic [63:0] bmask;

        // ---------------- reset state, requests pending during reset -------
        rst = 1'b1;
        res_ready = 1'b1;
        drive(0, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        drive(1, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        drive(0, 1'b1, c_op_jlt,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd10);
        drive(1, 1'b1, c_op_jltu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd11);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst takb", 64'(res_takb), 64'd0);
        chk("rst dec", res_dec, 64'd0);
        chk("rst decwr", 64'(res_decwr), 64'd0);
        chk("rst tag", 64'(res_tag), 64'd0);
        chk("rst src", 64'(res_src), 64'd0);
        chk("rst req0_ready", 64'(req0_ready), 64'd0);
        chk("rst req1_ready", 64'(req1_ready), 64'd0);

        // ---------------- contention: both valid from reset ----------------
        rst = 1'b0;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            if (c > 0) @(negedge clk);
            else #1;
            if (req0_ready && req1_ready) chk("ready one-hot", 64'(req1_ready), 64'd0);
            if (req0_ready && ng < 4) begin gr[ng] = 0; ng++; end
            else if (req1_ready && ng < 4) begin gr[ng] = 1; ng++; end
            if (res_valid && nr < 4) begin
                rs[nr] = int'(res_src); rt[nr] = int'(res_takb); rg[nr] = int'(res_tag); nr++;
            end
        end
        drive(0, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        drive(1, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        chk("contention results", 64'(nr), 64'd4);
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("contention grant%0d", i), 64'(gr[i]), 64'(i % 2));
            chk($sformatf("contention src%0d", i), 64'(rs[i]), 64'(i % 2));
            chk($sformatf("contention takb%0d", i), 64'(rt[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("contention tag%0d", i), 64'(rg[i]), (i % 2 == 0) ? 64'd10 : 64'd11);
        end
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------------------
        bmask = 64'h8000_0000_0000_0000;
        vecs.push_back(mk(0, c_op_jeq,  64'd5, 64'd5, 5'd3,  1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jne,  64'd5, 64'd6, 5'd7,  1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_jlt,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jltu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2, 1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_jge,  64'd3, 64'd3, 5'd4,  1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jgtu, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_jle,  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 5'd6, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jgt,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_jleu, 64'd5, 64'd4, 5'd9,  1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jeqz, 64'd0, 64'd7, 5'd12, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_jbs,  bmask, 64'd63, 5'd13, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_jbc,  bmask, 64'h1_0000_003F, 5'd14, 1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, 7'h00,     64'd0, 64'd0, 5'd15, 1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, 7'h3E,     64'd1, 64'd1, 5'd16, 1'b0, 64'd0, 1'b0, 2));
`ifdef THOR2021_DJ_EN
        vecs.push_back(mk(0, c_op_djnez, 64'd1, 64'd0, 5'd17, 1'b0, 64'd0, 1'b1, 3));
        vecs.push_back(mk(1, c_op_djnez, 64'd0, 64'd0, 5'd18, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3));
        vecs.push_back(mk(0, c_op_djeq,  64'd4, 64'd4, 5'd19, 1'b0, 64'd3, 1'b1, 3));
        vecs.push_back(mk(1, c_op_djbs,  64'd4, 64'd1, 5'd20, 1'b1, 64'd3, 1'b1, 3));
`else
        vecs.push_back(mk(0, c_op_djnez, 64'd1, 64'd0, 5'd17, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_djnez, 64'd0, 64'd0, 5'd18, 1'b0, 64'd0, 1'b0, 2));
        vecs.push_back(mk(0, c_op_djeq,  64'd4, 64'd4, 5'd19, 1'b1, 64'd0, 1'b0, 2));
        vecs.push_back(mk(1, c_op_djbs,  64'd4, 64'd1, 5'd20, 1'b0, 64'd0, 1'b0, 2));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // ---------------- backpressure -------------------------------------
        @(negedge clk);
        res_ready = 1'b0;
        drive(0, 1'b1, c_op_jeq, 64'd1, 64'd2, 5'd5);
        #1;
        seen = req0_ready;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            seen = req0_ready;
        end
        chk("bp accept", 64'(seen), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        drive(1, 1'b1, c_op_jeq, 64'd9, 64'd9, 5'd6);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("bp res_valid", 64'(seen), 64'd1);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (!(res_valid && busy && !req0_ready && !req1_ready && res_tag == 5'd5 &&
                  !res_takb && !res_src && res_dec == 64'd0 && !res_decwr)) ok = 1'b0;
        end
        chk("bp hold stable", 64'(ok), 64'd1);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp idle busy", 64'(busy), 64'd0);
        chk("bp idle res_valid", 64'(res_valid), 64'd0);
        chk("bp idle req1_ready", 64'(req1_ready), 64'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("bp second result", 64'(seen), 64'd1);
        chk("bp second tag", 64'(res_tag), 64'd6);
        chk("bp second src", 64'(res_src), 64'd1);
        chk("bp second takb", 64'(res_takb), 64'd1);
        @(posedge clk); #1;

        // ---------------- reset in the cycle after accept ------------------
        @(negedge clk);
        drive(0, 1'b1, c_op_djnez, 64'd5, 64'd0, 5'd21);
        #1;
        seen = req0_ready;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            seen = req0_ready;
        end
        chk("rstop accept", 64'(seen), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 7'd0, 64'd0, 64'd0, 5'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstop res_valid", 64'(res_valid), 64'd0);
        chk("rstop busy", 64'(busy), 64'd0);
        chk("rstop tag", 64'(res_tag), 64'd0);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid || busy) ok = 1'b0;
        end
        chk("rstop no result", 64'(ok), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
